// File: rtl/seq_det_1011.sv
// seq_det_1011: Moore-style detector for the serial pattern 1011 with a
// qualifying valid, a registered one-cycle match pulse and a saturating,
// synchronously clearable match counter.
module seq_det_1011 #(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned OVERLAP = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  input  logic             clr,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    S1    = 3'd1,
    S10   = 3'd2,
    S101  = 3'd3,
    S1011 = 3'd4
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             match_next;
  logic [CNT_W-1:0] cnt_next;

  // State register; reset discards any partial progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; the FSM only moves on qualified bits so din is ignored otherwise.
  always_comb begin
    state_next = state;
    if (din_valid) begin
      unique case (state)
        IDLE:    state_next = din ? S1    : IDLE;
        S1:      state_next = din ? S1    : S10;
        S10:     state_next = din ? S101  : IDLE;
        S101:    state_next = din ? S1011 : S10;
        S1011: begin
          if (din) begin
            state_next = S1;
          end else if (OVERLAP != 0) begin
            state_next = S10;
          end else begin
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Output logic; a match is the qualified edge that enters S1011, clear beats increment.
  always_comb begin
    match_next = 1'b0;
    cnt_next   = match_cnt;
    if (din_valid && din && (state == S101)) begin
      match_next = 1'b1;
    end
    if (clr) begin
      cnt_next = '0;
    end else if (match_next && (match_cnt != CNT_MAX)) begin
      cnt_next = match_cnt + CNT_W'(1);
    end
  end

  // Output registers so no input reaches an output combinationally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      match     <= 1'b0;
      match_cnt <= '0;
    end else begin
      match     <= match_next;
      match_cnt <= cnt_next;
    end
  end

endmodule

// File: doc/seq_det_1011.md
# seq_det_1011

Serial pattern detector that consumes the registered bit stream produced by the team's D flip-flop stage (its `q` output feeds `din`) and flags every occurrence of the 4-bit sequence 1011. It is a Moore-style FSM with a qualifying valid input, a one-cycle match pulse, and a saturating match counter with synchronous clear. It is the first consumer downstream of the flip-flop conversion stages and is verified by the same style of directed, display-driven bench.

## Interface
- `CNT_W`, default 8: width of the match counter.
- `OVERLAP`, default 1: 1 means overlapping matches are counted; 0 means detection restarts fresh after each match.

- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst`  input  1  asynchronous, active-low reset (`rst`=0 resets immediately, independent of `clk`).
- `din`  input  1  serial data bit, driven by the upstream flip-flop `q`.
- `din_valid`  input  1  `din` is sampled only on edges where this is 1.
- `clr`  input  1  synchronous clear of `match_cnt`; does not affect the FSM.
- `match`  output  1  one-cycle pulse when 1011 completes.
- `match_cnt`  output  CNT_W  number of matches since reset/clear, saturating.

## Operation
- States: IDLE, S1 ("1"), S10, S101, S1011. Encoding is free.
- State advances only on edges with `din_valid`=1. With `din_valid`=0, the state holds.
- Transitions, written as din=0 / din=1:
  - IDLE: IDLE / S1.
  - S1: S10 / S1.
  - S10: IDLE / S101.
  - S101: S10 / S1011.
  - S1011 with OVERLAP=1: S10 / S1.
  - S1011 with OVERLAP=0: IDLE / S1.
- `match` is registered. It is 1 for exactly the one cycle following the edge that moves the FSM into S1011.
  - It returns to 0 on the next edge even if `din_valid`=0 holds the FSM in S1011.
- `match_cnt` increments by 1 on the same edge that sets `match`.
  - It saturates at 2^CNT_W−1 and never wraps.
- Counter priority on one edge is clr > increment: `clr`=1 gives `match_cnt`=0 even when a match completes on that edge. `match` still pulses, and the FSM still advances.
- Reset values:
  - FSM state = IDLE.
  - `match` = 0.
  - `match_cnt` = 0.
- Reset mid-sequence discards all partial progress. After `rst` deasserts, detection starts from IDLE.
- X on `din` while `din_valid`=0 must not disturb the state.

## Timing
- Latency: the 4th pattern bit is sampled at edge N. `match`=1 and `match_cnt` is updated from just after edge N until edge N+1.
- Throughput: with OVERLAP=1, the minimum spacing between matches is 3 valid bits (1011011 gives 2 matches).
- No combinational path from inputs to outputs. All outputs are flops.
- `rst` assertion clears outputs asynchronously. Deassertion is assumed synchronous to `clk` by the system; the block contains no reset synchronizer.
- `clr` and `din_valid` act only at rising edges.

## Test plan
- OVERLAP=1: reset, then valid stream 1,0,1,1,0,1,1 on consecutive cycles → `match` pulses after bit 4 and after bit 7, and `match_cnt`=2.
- OVERLAP=0: same stream 1,0,1,1,0,1,1 → one pulse after bit 4 only, and `match_cnt`=1.
- Valid gaps: 1,0, then `din_valid`=0 for 3 cycles with `din` toggling, then 1,1 → one match and `match_cnt`=1. `match` stays high only one cycle even though `din_valid`=0 on the following cycles.
- Saturation: CNT_W=2, feed 5 back-to-back 1011 patterns → 5 `match` pulses, and `match_cnt` reads 1,2,3,3,3.
- Clear collision: `match_cnt`=2, then `clr`=1 on the edge completing a 1011 → `match`=1 and `match_cnt`=0. The next 1011 gives `match_cnt`=1.
- Reset mid-operation: feed 1,0,1, drive `rst`=0 between edges, then release and feed 1 → no match (S1 only), `match_cnt`=0. Then feed 0,1,1 → one match.
